// File: rtl/sid_filter_ctrl.sv
// sid_filter_ctrl
//   Register-mapped controller for the SID state-variable filter datapath.
//   Byte writes update shadow registers only. On each sample tick the
//   shadow-derived q coefficient, mode enables and volume are committed
//   together. The f coefficient moves toward its target by at most SLEW_STEP
//   per tick, which suppresses zipper noise.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   sample_tick       one-cycle pulse at the audio sample rate
//   wr_en/addr/data   register write port (addr 0..3)
//   f_coefficient     slew-limited f coefficient (two's complement)
//   q_coefficient     q coefficient (two's complement, 4096 = 1.0)
//   en_*              filter mode enables
//   volume            master volume
//   filter_ce         one-cycle filter clock-enable, aligned with coefficients
//   busy              high while f is ramping toward its target
//
// state | meaning
// IDLE  | f_coefficient equals the target of the last committed step
// RAMP  | f_coefficient still slewing toward its target
module sid_filter_ctrl #(
  parameter int FILTER_COEF_BDEPTH = 16,
  parameter int CUTOFF_BITS        = 11,
  parameter int F_MIN              = 30,
  parameter int F_SCALE            = 6,
  parameter int SLEW_STEP          = 64,
  parameter int Q_MAX              = 5792,
  parameter int Q_STEP             = 340
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sample_tick,
  input  logic                                 wr_en,
  input  logic [1:0]                           wr_addr,
  input  logic [7:0]                           wr_data,
  output logic signed [FILTER_COEF_BDEPTH-1:0] f_coefficient,
  output logic signed [FILTER_COEF_BDEPTH-1:0] q_coefficient,
  output logic                                 en_pass,
  output logic                                 en_lowpass,
  output logic                                 en_bandpass,
  output logic                                 en_highpass,
  output logic [3:0]                           volume,
  output logic                                 filter_ce,
  output logic                                 busy
);

  // Internal arithmetic is wide enough that cutoff*F_SCALE cannot wrap.
  localparam int CW = FILTER_COEF_BDEPTH + 4;
  localparam logic [CW-1:0] F_LIMIT = CW'((1 << (FILTER_COEF_BDEPTH - 1)) - 1);
  localparam logic [CW-1:0] SLEW_CW = CW'(SLEW_STEP);
  localparam logic [CW-1:0] QMAX_CW = CW'(Q_MAX);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t state_q, state_d;

  logic [CUTOFF_BITS-1:0] cutoff;
  logic [3:0]             res;
  logic                   sh_lp, sh_bp, sh_hp, sh_pass;
  logic [3:0]             sh_vol;

  logic [CW-1:0] f_wide, f_target, f_cur, f_next;
  logic [CW-1:0] q_drop, q_diff;
  logic [FILTER_COEF_BDEPTH-1:0] q_target;

  // Shadow registers; a write coincident with a tick lands here after the
  // commit has already sampled the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cutoff  <= '0;
      res     <= '0;
      sh_lp   <= 1'b0;
      sh_bp   <= 1'b0;
      sh_hp   <= 1'b0;
      sh_pass <= 1'b0;
      sh_vol  <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        2'd0: cutoff[2:0] <= wr_data[2:0];
        2'd1: cutoff[CUTOFF_BITS-1:3] <= wr_data[CUTOFF_BITS-4:0];
        2'd2: res <= wr_data[7:4];
        default: begin
          sh_lp   <= wr_data[4];
          sh_bp   <= wr_data[5];
          sh_hp   <= wr_data[6];
          sh_pass <= wr_data[7];
          sh_vol  <= wr_data[3:0];
        end
      endcase
    end
  end

  always_comb begin
    f_wide   = CW'(F_MIN) + CW'(cutoff) * CW'(F_SCALE);
    f_target = (f_wide > F_LIMIT) ? F_LIMIT : f_wide;

    q_drop   = CW'(res) * CW'(Q_STEP);
    q_diff   = (q_drop > QMAX_CW) ? '0 : (QMAX_CW - q_drop);
    q_target = q_diff[FILTER_COEF_BDEPTH-1:0];

    // f is never negative, so the unsigned view is exact.
    f_cur = CW'($unsigned(f_coefficient));
    if (f_target >= f_cur) begin
      f_next = ((f_target - f_cur) <= SLEW_CW) ? f_target : (f_cur + SLEW_CW);
    end else begin
      f_next = ((f_cur - f_target) <= SLEW_CW) ? f_target : (f_cur - SLEW_CW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_coefficient <= FILTER_COEF_BDEPTH'(F_MIN);
      q_coefficient <= FILTER_COEF_BDEPTH'(Q_MAX);
      en_pass       <= 1'b0;
      en_lowpass    <= 1'b0;
      en_bandpass   <= 1'b0;
      en_highpass   <= 1'b0;
      volume        <= '0;
      filter_ce     <= 1'b0;
    end else begin
      filter_ce <= sample_tick;
      if (sample_tick) begin
        f_coefficient <= f_next[FILTER_COEF_BDEPTH-1:0];
        q_coefficient <= q_target;
        en_pass       <= sh_pass;
        en_lowpass    <= sh_lp;
        en_bandpass   <= sh_bp;
        en_highpass   <= sh_hp;
        volume        <= sh_vol;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Both states resolve the same way on a tick, so a target change mid-ramp
  // simply redirects the next step with no restart delay.
  always_comb begin
    state_d = state_q;
    if (sample_tick) begin
      state_d = (f_next != f_target) ? RAMP : IDLE;
    end
  end

  assign busy = (state_q == RAMP);

endmodule

// File: tb/tb_sid_filter_ctrl.sv
module tb_sid_filter_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sample_tick;
  logic               wr_en;
  logic [1:0]         wr_addr;
  logic [7:0]         wr_data;
  logic signed [15:0] f_coefficient;
  logic signed [15:0] q_coefficient;
  logic               en_pass, en_lowpass, en_bandpass, en_highpass;
  logic [3:0]         volume;
  logic               filter_ce;
  logic               busy;

  int checks = 0;
  int errors = 0;

  sid_filter_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .f_coefficient(f_coefficient),
    .q_coefficient(q_coefficient),
    .en_pass      (en_pass),
    .en_lowpass   (en_lowpass),
    .en_bandpass  (en_bandpass),
    .en_highpass  (en_highpass),
    .volume       (volume),
    .filter_ce    (filter_ce),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_tick = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
    repeat (2) @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    checks++;
    if (filter_ce !== 1'b0) begin errors++; $display("FAIL reset_tick_ignored: filter_ce got %b expected 0", filter_ce); end
    checks++;
    if (f_coefficient !== 16'sd30) begin errors++; $display("FAIL reset_tick_f: got %0d expected 30", f_coefficient); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_tick();
    checks++;
    if (filter_ce !== 1'b1) begin errors++; $display("FAIL reset_ce_high: got %b expected 1", filter_ce); end
    checks++;
    if (f_coefficient !== 16'sd30) begin errors++; $display("FAIL reset_f: got %0d expected 30", f_coefficient); end
    checks++;
    if (q_coefficient !== 16'sd5792) begin errors++; $display("FAIL reset_q: got %0d expected 5792", q_coefficient); end
    checks++;
    if ({en_pass, en_lowpass, en_bandpass, en_highpass} !== 4'b0000) begin
      errors++; $display("FAIL reset_enables: got %b expected 0000", {en_pass, en_lowpass, en_bandpass, en_highpass});
    end
    checks++;
    if (volume !== 4'd0) begin errors++; $display("FAIL reset_volume: got %0d expected 0", volume); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (filter_ce !== 1'b0) begin errors++; $display("FAIL reset_ce_one_cycle: got %b expected 0", filter_ce); end
  endtask

  task automatic test_small_step();
    do_write(2'd0, 8'h05);
    do_write(2'd1, 8'h00);
    checks++;
    if (f_coefficient !== 16'sd30) begin errors++; $display("FAIL small_write_no_effect: got %0d expected 30", f_coefficient); end
    do_tick();
    checks++;
    if (f_coefficient !== 16'sd60) begin errors++; $display("FAIL small_f: got %0d expected 60", f_coefficient); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL small_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_ramp();
    int exp_f;
    apply_reset();
    do_write(2'd0, 8'h07);
    do_write(2'd1, 8'hFF);
    for (int k = 1; k <= 192; k++) begin
      do_tick();
      exp_f = (30 + 64 * k > 12312) ? 12312 : 30 + 64 * k;
      checks++;
      if (f_coefficient !== 16'(exp_f)) begin
        errors++; $display("FAIL ramp_f tick %0d: got %0d expected %0d", k, f_coefficient, exp_f);
      end
      checks++;
      if (busy !== (k < 192)) begin
        errors++; $display("FAIL ramp_busy tick %0d: got %b expected %b", k, busy, (k < 192));
      end
    end
    do_tick();
    checks++;
    if (f_coefficient !== 16'sd12312 || busy !== 1'b0) begin
      errors++; $display("FAIL ramp_hold: got f=%0d busy=%b expected f=12312 busy=0", f_coefficient, busy);
    end
  endtask

  task automatic test_reversal();
    // cutoff 1024 -> target 6174, ramp down from 12312
    do_write(2'd0, 8'h00);
    do_write(2'd1, 8'h80);
    do_tick();
    checks++;
    if (f_coefficient !== 16'sd12248 || busy !== 1'b1) begin
      errors++; $display("FAIL rev_down1: got f=%0d busy=%b expected f=12248 busy=1", f_coefficient, busy);
    end
    do_tick();
    do_tick();
    checks++;
    if (f_coefficient !== 16'sd12120) begin errors++; $display("FAIL rev_down3: got %0d expected 12120", f_coefficient); end
    // back to cutoff 2047 mid-ramp: direction reverses
    do_write(2'd0, 8'h07);
    do_write(2'd1, 8'hFF);
    do_tick();
    checks++;
    if (f_coefficient !== 16'sd12184 || busy !== 1'b1) begin
      errors++; $display("FAIL rev_up1: got f=%0d busy=%b expected f=12184 busy=1", f_coefficient, busy);
    end
    do_tick();
    do_tick();
    checks++;
    if (f_coefficient !== 16'sd12312 || busy !== 1'b0) begin
      errors++; $display("FAIL rev_settle: got f=%0d busy=%b expected f=12312 busy=0", f_coefficient, busy);
    end
  endtask

  task automatic test_mode_volume();
    do_write(2'd2, 8'hF0);
    do_write(2'd3, 8'h5A);
    checks++;
    if (q_coefficient !== 16'sd5792 || volume !== 4'd0 || en_lowpass !== 1'b0) begin
      errors++; $display("FAIL mode_write_no_effect: got q=%0d vol=%0d lp=%b expected 5792 0 0", q_coefficient, volume, en_lowpass);
    end
    do_tick();
    checks++;
    if (q_coefficient !== 16'sd692) begin errors++; $display("FAIL mode_q: got %0d expected 692", q_coefficient); end
    checks++;
    if ({en_pass, en_lowpass, en_bandpass, en_highpass} !== 4'b0101) begin
      errors++; $display("FAIL mode_enables: got %b expected 0101 (pass,lp,bp,hp)", {en_pass, en_lowpass, en_bandpass, en_highpass});
    end
    checks++;
    if (volume !== 4'd10) begin errors++; $display("FAIL mode_volume: got %0d expected 10", volume); end
    checks++;
    if (f_coefficient !== 16'sd12312) begin errors++; $display("FAIL mode_f_kept: got %0d expected 12312", f_coefficient); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h10; sample_tick = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; sample_tick = 1'b0;
    checks++;
    if ({en_pass, en_lowpass, en_bandpass, en_highpass} !== 4'b0101 || volume !== 4'd10) begin
      errors++; $display("FAIL collide_old: got en=%b vol=%0d expected en=0101 vol=10",
                         {en_pass, en_lowpass, en_bandpass, en_highpass}, volume);
    end
    do_tick();
    checks++;
    if ({en_pass, en_lowpass, en_bandpass, en_highpass} !== 4'b0100 || volume !== 4'd0) begin
      errors++; $display("FAIL collide_new: got en=%b vol=%0d expected en=0100 vol=0",
                         {en_pass, en_lowpass, en_bandpass, en_highpass}, volume);
    end
  endtask

  task automatic test_async_reset();
    do_write(2'd0, 8'h00);
    do_write(2'd1, 8'h00);
    do_tick();
    do_tick();
    checks++;
    if (f_coefficient !== 16'sd12184 || busy !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got f=%0d busy=%b expected f=12184 busy=1", f_coefficient, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (f_coefficient !== 16'sd30 || q_coefficient !== 16'sd5792) begin
      errors++; $display("FAIL areset_coef: got f=%0d q=%0d expected 30 5792", f_coefficient, q_coefficient);
    end
    checks++;
    if (busy !== 1'b0 || en_lowpass !== 1'b0 || volume !== 4'd0) begin
      errors++; $display("FAIL areset_ctrl: got busy=%b lp=%b vol=%0d expected 0 0 0", busy, en_lowpass, volume);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) do_tick();
    checks++;
    if (f_coefficient !== 16'sd30 || busy !== 1'b0) begin
      errors++; $display("FAIL areset_no_resume: got f=%0d busy=%b expected 30 0", f_coefficient, busy);
    end
    do_write(2'd0, 8'h05);
    do_tick();
    checks++;
    if (f_coefficient !== 16'sd60) begin errors++; $display("FAIL areset_new_write: got %0d expected 60", f_coefficient); end
  endtask

  initial begin
    test_reset();
    test_small_step();
    test_full_ramp();
    test_reversal();
    test_mode_volume();
    test_collision();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
